mult_div_sequencer: RTL and testbench

Iterative multiply/divide unit with its own HI/LO registers, sequenced by a small FSM, that sits beside the main ALU in the EX stage. It accepts MULT/MULTU/DIV/DIVU from the EX stage through a start/busy/done handshake. It raises a pipeline stall while an operation is in flight and a dependent HI/LO access or new start arrives. It also serves MFHI/MFLO reads and MTHI/MTLO writes.

---
 rtl/mult_div_sequencer_pkg.sv | 20 ++
 rtl/mult_div_step.sv | 33 +++
 rtl/mult_div_sequencer.sv | 153 +++++++++++++++
 tb/tb_mult_div_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_sequencer_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, default width.
package mult_div_sequencer_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 5;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFix  = 2'b10
  } state_e;

endpackage

// File: rtl/mult_div_step.sv
// One radix-2 iteration: MSB-first shift-add multiply or restoring shift-subtract divide.
module mult_div_step
  import mult_div_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    i_is_div,
  input  logic [2*DATA_WIDTH-1:0] i_acc,   // mul: partial product; div: {remainder, quotient}
  input  logic [DATA_WIDTH-1:0]   i_sh,    // mul: multiplier; div: dividend (consumed MSB first)
  input  logic [DATA_WIDTH-1:0]   i_opnd,  // mul: multiplicand; div: divisor
  output logic [2*DATA_WIDTH-1:0] o_acc,
  output logic [DATA_WIDTH-1:0]   o_sh
);

  logic [DATA_WIDTH:0] w_rem_sh;
  logic [DATA_WIDTH:0] w_diff;
  logic                w_ge;

  always_comb begin
    w_rem_sh = {i_acc[2*DATA_WIDTH-1:DATA_WIDTH], i_sh[DATA_WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, i_opnd};
    w_ge     = ~w_diff[DATA_WIDTH];
    o_sh     = {i_sh[DATA_WIDTH-2:0], 1'b0};
    if (i_is_div) begin
      o_acc = {(w_ge ? w_diff[DATA_WIDTH-1:0] : w_rem_sh[DATA_WIDTH-1:0]),
               i_acc[DATA_WIDTH-2:0], w_ge};
    end else begin
      o_acc = {i_acc[2*DATA_WIDTH-2:0], 1'b0}
            + (i_sh[DATA_WIDTH-1] ? {{DATA_WIDTH{1'b0}}, i_opnd} : '0);
    end
  end

endmodule

// File: rtl/mult_div_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO, start/busy/done handshake and EX stall.
// Signed ops are built only when MULT_DIV_SIGNED_EN is defined; otherwise op[0] is ignored.
module mult_div_sequencer
  import mult_div_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] rs_i,
  input  logic [DATA_WIDTH-1:0] rt_i,
  input  logic                  rd_hilo_i,
  input  logic                  wr_hi_i,
  input  logic                  wr_lo_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div_zero_o,
  output logic                  stall_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  state_e                  r_state, w_state_nxt;
  logic                    r_is_div;
  logic [2*DATA_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [DATA_WIDTH-1:0]   r_sh, w_sh_nxt;
  logic [DATA_WIDTH-1:0]   r_opnd;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [DATA_WIDTH-1:0]   r_hi, r_lo;
  logic                    r_busy, r_done, r_div_zero;

  logic                    w_signed_in;
  logic [DATA_WIDTH-1:0]   w_rs_abs, w_rt_abs;
  logic [2*DATA_WIDTH-1:0] w_prod;
  logic [DATA_WIDTH-1:0]   w_quo, w_rem, w_hi_res, w_lo_res;

`ifdef MULT_DIV_SIGNED_EN
  logic r_sign_a, r_sign_b;
  assign w_signed_in = op_i[0];
`else
  logic w_unused_op0;
  assign w_unused_op0 = op_i[0];
  assign w_signed_in  = 1'b0;
`endif

  assign w_rs_abs = (w_signed_in && rs_i[DATA_WIDTH-1]) ? -rs_i : rs_i;
  assign w_rt_abs = (w_signed_in && rt_i[DATA_WIDTH-1]) ? -rt_i : rt_i;

  mult_div_step #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_step (
    .i_is_div(r_is_div),
    .i_acc   (r_acc),
    .i_sh    (r_sh),
    .i_opnd  (r_opnd),
    .o_acc   (w_acc_nxt),
    .o_sh    (w_sh_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (start_i) w_state_nxt = StCalc;
      StCalc:  if (r_cnt == CNT_LAST) w_state_nxt = StFix;
      StFix:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Magnitude result fix-up: product/quotient negate on sign mismatch, remainder follows dividend.
  always_comb begin
    w_prod = r_acc;
    w_quo  = r_acc[DATA_WIDTH-1:0];
    w_rem  = r_acc[2*DATA_WIDTH-1:DATA_WIDTH];
`ifdef MULT_DIV_SIGNED_EN
    if (r_sign_a ^ r_sign_b) begin
      w_prod = -r_acc;
      w_quo  = -r_acc[DATA_WIDTH-1:0];
    end
    if (r_sign_a) w_rem = -r_acc[2*DATA_WIDTH-1:DATA_WIDTH];
`endif
    w_hi_res = r_is_div ? w_rem : w_prod[2*DATA_WIDTH-1:DATA_WIDTH];
    w_lo_res = r_is_div ? w_quo : w_prod[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_is_div   <= 1'b0;
      r_acc      <= '0;
      r_sh       <= '0;
      r_opnd     <= '0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
`ifdef MULT_DIV_SIGNED_EN
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (wr_hi_i) r_hi <= wdata_i;
          if (wr_lo_i) r_lo <= wdata_i;
          if (start_i) begin
            r_is_div   <= op_i[1];
            r_opnd     <= op_i[1] ? w_rt_abs : w_rs_abs;
            r_sh       <= op_i[1] ? w_rs_abs : w_rt_abs;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_div_zero <= op_i[1] && (rt_i == '0);
`ifdef MULT_DIV_SIGNED_EN
            r_sign_a   <= w_signed_in & rs_i[DATA_WIDTH-1];
            r_sign_b   <= w_signed_in & rt_i[DATA_WIDTH-1];
`endif
          end
        end
        StCalc: begin
          r_acc <= w_acc_nxt;
          r_sh  <= w_sh_nxt;
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
        StFix: begin
          r_hi   <= w_hi_res;
          r_lo   <= w_lo_res;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign hi_o       = r_hi;
  assign lo_o       = r_lo;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign div_zero_o = r_div_zero;
  assign stall_o    = r_busy & (start_i | rd_hilo_i | wr_hi_i | wr_lo_i);

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Randomised + directed bench for mult_div_sequencer against an arithmetic reference model.
module tb_mult_div_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start, rd_hilo, wr_hi, wr_lo;
  logic [1:0]   op;
  logic [W-1:0] rs, rt, wdata, hi, lo;
  logic         busy, done, dz, stall;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mult_div_sequencer u_dut (
    .clk       (clk),
    .reset     (reset),
    .start_i   (start),
    .op_i      (op),
    .rs_i      (rs),
    .rt_i      (rt),
    .rd_hilo_i (rd_hilo),
    .wr_hi_i   (wr_hi),
    .wr_lo_i   (wr_lo),
    .wdata_i   (wdata),
    .hi_o      (hi),
    .lo_o      (lo),
    .busy_o    (busy),
    .done_o    (done),
    .div_zero_o(dz),
    .stall_o   (stall)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definitions.
  function automatic void model(input logic [1:0] mop, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] ehi, output logic [W-1:0] elo);
    bit           sgn;
    bit           na, nb;
    logic [63:0]  p;
    longint       sa, sb;
    logic [W-1:0] ua, ub, uq, ur;
    sgn = 1'b0;
`ifdef MULT_DIV_SIGNED_EN
    sgn = mop[0];
`endif
    if (!mop[1]) begin
      if (sgn) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
      end else begin
        p = {32'b0, a} * {32'b0, b};
      end
      ehi = p[63:32];
      elo = p[31:0];
    end else begin
      na = sgn && a[W-1];
      nb = sgn && b[W-1];
      ua = na ? -a : a;
      ub = nb ? -b : b;
      if (ub == 0) begin
        uq = '1;
        ur = ua;
      end else begin
        uq = ua / ub;
        ur = ua % ub;
      end
      elo = (na ^ nb) ? -uq : uq;
      ehi = na ? -ur : ur;
    end
  endfunction

  // Issue one op, check acceptance, latency, result and the one-cycle done pulse.
  task automatic run_op(input logic [1:0] mop, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ehi, elo;
    int n;
    model(mop, a, b, ehi, elo);
    @(negedge clk);
    start = 1'b1; op = mop; rs = a; rt = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("dz_after_start", dz, (mop[1] && b == 0));
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("latency", n, 33);
    check_eq("hi", hi, ehi);
    check_eq("lo", lo, elo);
    check_eq("dz_at_done", dz, (mop[1] && b == 0));
    check_eq("busy_at_done", busy, 0);
    @(negedge clk);
    check_eq("done_pulse", done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    logic [1:0]   mop;
    int           n;
    bit           ok;
    reset = 1'b0; start = 0; op = 0; rs = 0; rt = 0;
    rd_hilo = 0; wr_hi = 0; wr_lo = 0; wdata = 0;
    #12;
    check_eq("rst_hi", hi, 0);
    check_eq("rst_lo", lo, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_dz", dz, 0);
    check_eq("rst_stall", stall, 0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_eq("multu_max_hi", hi, 32'hFFFF_FFFE);
    check_eq("multu_max_lo", lo, 32'h0000_0001);
    run_op(2'b10, 32'd100, 32'd7);
    check_eq("divu_lo", lo, 14);
    check_eq("divu_hi", hi, 2);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2);
`ifdef MULT_DIV_SIGNED_EN
    check_eq("div_neg_lo", lo, 32'hFFFF_FFFD);
    check_eq("div_neg_hi", hi, 32'hFFFF_FFFF);
`else
    check_eq("div_neg_lo", lo, 32'h7FFF_FFFC);
    check_eq("div_neg_hi", hi, 32'h0000_0001);
`endif
    run_op(2'b10, 32'h1234, 32'd0);
    check_eq("dz_lo", lo, 32'hFFFF_FFFF);
    check_eq("dz_hi", hi, 32'h1234);
    repeat (3) @(negedge clk);
    check_eq("dz_sticky", dz, 1);

    // MTHI+MTLO in the same idle cycle write both
    @(negedge clk);
    wr_hi = 1; wr_lo = 1; wdata = 32'h0BAD_F00D;
    @(negedge clk);
    wr_hi = 0; wr_lo = 0;
    check_eq("mthi", hi, 32'h0BAD_F00D);
    check_eq("mtlo", lo, 32'h0BAD_F00D);

    // Stall: MULTU 3*5, then MFHI access and a held DIVU 9/4
    @(negedge clk);
    start = 1; op = 2'b00; rs = 3; rt = 5;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    check_eq("dz_cleared", dz, 0);
    n = 0;
    repeat (9) begin
      @(negedge clk);
      n++;
    end
    check_eq("no_stall_idle_inputs", stall, 0);
    rd_hilo = 1;
    #1 check_eq("stall_rd", stall, 1);
    @(negedge clk);
    n++;
    rd_hilo = 0; start = 1; op = 2'b10; rs = 9; rt = 4;
    ok = 1;
    while (!done && n < 100) begin
      #1 if (!stall) ok = 0;
      @(negedge clk);
      n++;
    end
    check_eq("stall_held", ok, 1);
    check_eq("stall_lat", n, 33);
    check_eq("stall_first_lo", lo, 15);
    check_eq("stall_first_hi", hi, 0);
    @(posedge clk);
    @(negedge clk);
    start = 0;
    check_eq("second_accepted", busy, 1);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("second_lat", n, 33);
    check_eq("second_lo", lo, 2);
    check_eq("second_hi", hi, 1);

    // Asynchronous abort mid-operation
    @(negedge clk);
    start = 1; op = 2'b01; rs = 32'hFFFF_FFFD; rt = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    reset = 0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_hi", hi, 0);
    check_eq("abort_lo", lo, 0);
    check_eq("abort_done", done, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    wr_lo = 1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    wr_lo = 0;
    check_eq("post_abort_lo", lo, 32'hA5A5_A5A5);
    check_eq("post_abort_hi", hi, 0);
    repeat (40) @(negedge clk);
    check_eq("post_abort_idle", busy, 0);

    // Randomised ops with some corner operands
    for (int i = 0; i < 40; i++) begin
      mop = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 0;
        1: a = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(mop, a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
